// File: rtl/fifo_param.sv
// +--------------------------------------------------------------------------+
// | fifo_param : parametrised synchronous FIFO, registered or FWFT read port |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fifo_param #(
  parameter int FIFO_DATA_WIDTH = 20,
  parameter int DEPTH           = 16,
  parameter int AF_THRESH       = 14,
  parameter int AE_THRESH       = 2,
  parameter int FWFT            = 0,
  localparam int CNT_W          = $clog2(DEPTH) + 1,
  localparam int PTR_W          = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       clr_err,
  input  logic [FIFO_DATA_WIDTH-1:0] data_in,
  input  logic                       writep,
  input  logic                       readp,
  output logic [FIFO_DATA_WIDTH-1:0] data_out,
  output logic                       fullp,
  output logic                       emptyp,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [CNT_W-1:0]           count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam logic [CNT_W-1:0] c_full   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_af_lvl = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] c_ae_lvl = CNT_W'(AE_THRESH);

  logic [FIFO_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic                       underflow_q, underflow_d;
  logic                       wr_ok, rd_ok;

  assign count        = count_q;
  assign fullp        = (count_q == c_full);
  assign emptyp       = (count_q == '0);
  assign almost_full  = (count_q >= c_af_lvl);
  assign almost_empty = (count_q <= c_ae_lvl);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    // flush suppresses every accept and every new error event
    rd_ok       = ~flush & readp & ~emptyp;
    wr_ok       = ~flush & writep & (~fullp | rd_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (writep & fullp & ~rd_ok) overflow_d  = 1'b1;
      if (readp & emptyp)          underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft_out
      assign data_out = mem_q[rd_ptr_q];
    end else begin : g_reg_out
      logic [FIFO_DATA_WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (flush)      dout_d = '0;
        else if (rd_ok) dout_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fifo_param.sv
// +--------------------------------------------------------------------------+
// | tb_fifo_param : directed bench for fifo_param, registered and FWFT modes |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        clr_err = 1'b0;
  logic [19:0] din = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [19:0] dout;
  logic        full, empty, afull, aempty, ovf, udf;
  logic [4:0]  cnt;

  logic [19:0] din1 = '0;
  logic        wr1 = 1'b0;
  logic        rd1 = 1'b0;
  logic [19:0] dout1;
  logic        full1, empty1, afull1, aempty1, ovf1, udf1;
  logic [4:0]  cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_param #(.FIFO_DATA_WIDTH(20), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .data_in(din), .writep(wr), .readp(rd), .data_out(dout),
    .fullp(full), .emptyp(empty), .almost_full(afull), .almost_empty(aempty),
    .count(cnt), .overflow(ovf), .underflow(udf)
  );

  fifo_param #(.FIFO_DATA_WIDTH(20), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .data_in(din1), .writep(wr1), .readp(rd1), .data_out(dout1),
    .fullp(full1), .emptyp(empty1), .almost_full(afull1), .almost_empty(aempty1),
    .count(cnt1), .overflow(ovf1), .underflow(udf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // async reset asserted mid-cycle, before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(aempty), 32'd1);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(afull), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_udf", 32'(udf), 32'd0);
    chk("rst_fwft_empty", 32'(empty1), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // fill with 1..16, flags track count
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; din = 20'(i);
      step();
      chk("fill_count", 32'(cnt), 32'(i));
      chk("fill_afull", 32'(afull), (i >= 14) ? 32'd1 : 32'd0);
      chk("fill_aempty", 32'(aempty), (i <= 2) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
    end
    din = 20'h000FF;
    step();
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(cnt), 32'd16);
    wr = 1'b0;

    // drain: same order, one-cycle registered latency
    for (int i = 1; i <= 16; i++) begin
      rd = 1'b1;
      step();
      chk("drain_data", 32'(dout), 32'(i));
      chk("drain_count", 32'(cnt), 32'(16 - i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step();
    chk("udf_set", 32'(udf), 32'd1);
    chk("udf_dout_hold", 32'(dout), 32'h10);
    rd = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_udf", 32'(udf), 32'd0);

    // wrap: 10 writes, 10 overlapped write+read, 10 reads
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1; din = 20'h100 + 20'(i);
      step();
    end
    chk("wrap_fill_count", 32'(cnt), 32'd10);
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1; rd = 1'b1; din = 20'h200 + 20'(i);
      step();
      chk("wrap_ovl_data", 32'(dout), 32'h100 + 32'(i));
      chk("wrap_ovl_count", 32'(cnt), 32'd10);
    end
    wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd = 1'b1;
      step();
      chk("wrap_drain_data", 32'(dout), 32'h200 + 32'(i));
    end
    rd = 1'b0;
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_no_err", 32'({ovf, udf}), 32'd0);

    // full with simultaneous write and read
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; din = 20'h300 + 20'(i);
      step();
    end
    chk("sim_full", 32'(full), 32'd1);
    wr = 1'b1; rd = 1'b1; din = 20'h3FF;
    step();
    chk("sim_full_count", 32'(cnt), 32'd16);
    chk("sim_full_noovf", 32'(ovf), 32'd0);
    chk("sim_full_data", 32'(dout), 32'h300);
    wr = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("sim_drain_data", 32'(dout), 32'h300 + 32'(i));
    end
    step();
    chk("sim_drain_last", 32'(dout), 32'h3FF);
    chk("sim_drain_empty", 32'(empty), 32'd1);

    // empty with simultaneous write and read
    wr = 1'b1; rd = 1'b1; din = 20'h4AA;
    step();
    chk("sim_empty_count", 32'(cnt), 32'd1);
    chk("sim_empty_udf", 32'(udf), 32'd1);
    chk("sim_empty_dout_hold", 32'(dout), 32'h3FF);
    wr = 1'b0;
    step();
    chk("sim_empty_word", 32'(dout), 32'h4AA);
    chk("sim_empty_count0", 32'(cnt), 32'd0);
    rd = 1'b0;

    // flush at count 5 with writep asserted; underflow is still set
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; din = 20'h500 + 20'(i);
      step();
    end
    chk("flush_pre_count", 32'(cnt), 32'd5);
    flush = 1'b1; din = 20'h5FF;
    step();
    flush = 1'b0; wr = 1'b0;
    chk("flush_count", 32'(cnt), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_dout", 32'(dout), 32'd0);
    chk("flush_udf_kept", 32'(udf), 32'd1);
    chk("flush_ovf_kept", 32'(ovf), 32'd0);
    // pointers restart at 0 after flush
    wr = 1'b1; din = 20'h555;
    step();
    wr = 1'b0; rd = 1'b1;
    step();
    rd = 1'b0;
    chk("post_flush_data", 32'(dout), 32'h555);
    // clear and new error in the same cycle: error wins
    clr_err = 1'b1; rd = 1'b1;
    step();
    rd = 1'b0;
    chk("clr_vs_err", 32'(udf), 32'd1);
    step();
    clr_err = 1'b0;
    chk("clr_err_udf", 32'(udf), 32'd0);

    // FWFT: word visible the cycle after the write, no readp needed
    wr1 = 1'b1; din1 = 20'hABCDE;
    step();
    wr1 = 1'b0;
    chk("fwft_empty", 32'(empty1), 32'd0);
    chk("fwft_dout", 32'(dout1), 32'hABCDE);
    chk("fwft_count", 32'(cnt1), 32'd1);
    rd1 = 1'b1;
    step();
    rd1 = 1'b0;
    chk("fwft_pop_empty", 32'(empty1), 32'd1);

    // async reset mid-operation
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; din = 20'h700 + 20'(i);
      step();
    end
    wr = 1'b0; rd = 1'b1;
    step();
    rd = 1'b0;
    chk("pre_rst_dout", 32'(dout), 32'h700);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(cnt), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_count", 32'(cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
